// File: rtl/apb_arb_pkg.sv
// Shared types and default sizing for the APB requester arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

  localparam int APB_ARB_WIDTH   = 16;
  localparam int APB_ARB_NREQ    = 4;
  localparam int APB_ARB_TIMEOUT = 15;

  // Index width for a requester number; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester after i_last_grant,
// wrapping modulo NREQ.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int NREQ = APB_ARB_NREQ,
  localparam int GW   = idx_width(NREQ)
)(
  input  logic [NREQ-1:0] i_eligible,
  input  logic [GW-1:0]   i_last_grant,
  output logic [GW-1:0]   o_grant,
  output logic            o_any_valid
);

  logic [GW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = GW'((int'(i_last_grant) + k) % NREQ);
      if (!w_found && i_eligible[w_idx]) begin
        o_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_any_valid = w_found;

endmodule

// File: rtl/apb_req_arbiter.sv
// APB master shared by NREQ requesters, granted round-robin with back-to-back transfers.
// Optional ACCESS wait timeout enabled by defining APB_ARB_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | no transfer; arbitrate pending requests
//   SETUP  | psel=1, penable=0 for the granted requester
//   ACCESS | psel=1, penable=1; wait for pready (or timeout)
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int WIDTH   = APB_ARB_WIDTH,
  parameter int NREQ    = APB_ARB_NREQ,
  parameter int TIMEOUT = APB_ARB_TIMEOUT
)(
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_write,
  input  logic [NREQ*WIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [WIDTH-1:0]      rdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [WIDTH-1:0]      paddr,
  output logic [WIDTH-1:0]      pwdata,
  input  logic                  pready,
  input  logic [WIDTH-1:0]      prdata
);

  localparam int GW = idx_width(NREQ);

  arb_state_t       r_state, w_state_nxt;
  logic [GW-1:0]    r_grant, r_last_grant;
  logic             r_psel, r_penable, r_pwrite;
  logic [WIDTH-1:0] r_paddr, r_pwdata, r_rdata;
  logic [NREQ-1:0]  r_done;

  logic [NREQ-1:0]  w_eligible, w_grant_oh;
  logic [GW-1:0]    w_ptr, w_arb_grant;
  logic             w_arb_valid, w_complete, w_abort, w_load;
  logic             w_psel_nxt, w_penable_nxt;

  assign w_grant_oh = NREQ'(1) << r_grant;
  assign w_complete = (r_state == ACCESS) && pready;

  // The finishing requester and anyone still showing done sit this round out.
  assign w_eligible = req & ~r_done & (w_complete ? ~w_grant_oh : '1);
  assign w_ptr      = w_complete ? r_grant : r_last_grant;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_eligible   (w_eligible),
    .i_last_grant (w_ptr),
    .o_grant      (w_arb_grant),
    .o_any_valid  (w_arb_valid)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait;
  logic          r_err;

  // Abort on the wait cycle that would bring the counter to TIMEOUT.
  assign w_abort = (r_state == ACCESS) && !pready && (r_wait == CW'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (r_state == SETUP)
        r_wait <= '0;
      else if ((r_state == ACCESS) && !pready)
        r_wait <= r_wait + CW'(1);
    end
  end

  assign err = r_err;
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        w_penable_nxt = 1'b0;
        if (w_arb_valid) begin
          w_load      = 1'b1;
          w_psel_nxt  = 1'b1;
          w_state_nxt = SETUP;
        end else begin
          w_psel_nxt = 1'b0;
        end
      end
      SETUP: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        w_state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (w_complete && w_arb_valid) begin
          w_load        = 1'b1;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = SETUP;
        end else if (w_complete || w_abort) begin
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NREQ - 1);
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rdata      <= '0;
      r_done       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_done    <= (w_complete || w_abort) ? w_grant_oh : '0;
      if (w_complete || w_abort)
        r_last_grant <= r_grant;
      if (w_complete && !r_pwrite)
        r_rdata <= prdata;
      if (w_load) begin
        r_grant  <= w_arb_grant;
        r_pwrite <= req_write[w_arb_grant];
        r_paddr  <= req_addr[w_arb_grant*WIDTH +: WIDTH];
        r_pwdata <= req_wdata[w_arb_grant*WIDTH +: WIDTH];
      end
    end
  end

  assign done    = r_done;
  assign rdata   = r_rdata;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- WIDTH, 16, APB address and data width.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 15, maximum ACCESS wait cycles (used only under APB_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have one clock, pclk; reset SHALL be preset_n, asynchronous and active-low.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- pclk, in, 1, clock.
- preset_n, in, 1, async active-low reset.
- req, in, NREQ, per-requester transfer request.
- req_write, in, NREQ, per-requester 1=write, 0=read.
- req_addr, in, NREQ*WIDTH, flattened addresses; requester i at [i*WIDTH +: WIDTH].
- req_wdata, in, NREQ*WIDTH, flattened write data, same packing.
- done, out, NREQ, one-cycle completion pulse per requester.
- err, out, 1, valid with done; 1 = transfer aborted.
- rdata, out, WIDTH, read data of the last completed read.
- psel, penable, pwrite, out, 1 each, APB control.
- paddr, pwdata, out, WIDTH each, APB address and write data.
- pready, in, 1, APB ready.
- prdata, in, WIDTH, APB read data.

Function
REQ-004 The block SHALL implement states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-005 IDLE with any eligible req SHALL grant by round-robin, search starting at last_grant+1 mod NREQ.
- Same edge: latch that requester's addr, wdata and write into paddr, pwdata, pwrite.
- Same edge: psel=1, penable=0, go to SETUP.
REQ-006 IDLE with no eligible req SHALL keep psel=0 and penable=0.
REQ-007 SETUP SHALL always go to ACCESS with penable=1 and psel=1.
REQ-008 ACCESS with pready=0 SHALL hold all APB outputs stable.
REQ-009 ACCESS with pready=1 SHALL complete the transfer on that edge.
- done[grant] pulses for exactly the next cycle with err=0.
- For a read, rdata<=prdata; for a write, rdata is unchanged.
- last_grant<=grant.
REQ-010 At the completion edge, arbitration SHALL exclude the completing requester.
- Another eligible req: latch it, psel=1, penable=0, go to SETUP (back-to-back, no IDLE cycle).
- Otherwise: psel=0, penable=0, go to IDLE.
REQ-011 A requester's req SHALL be ineligible in any cycle its done bit is high.
REQ-012 A requester SHALL hold req and its data stable until its done; a req drop mid-transfer SHALL be ignored and the transfer SHALL complete.
REQ-013 At most one done bit SHALL be high per cycle; no transfer SHALL ever be granted twice.

Reset
REQ-014 preset_n low SHALL force the following at once, independent of pclk:
- state=IDLE, psel=penable=pwrite=0, paddr=pwdata=rdata=0.
- done=0, err=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-015 Reset mid-transfer SHALL abandon the transfer with no done pulse.

Configuration
REQ-016 With APB_ARB_TIMEOUT_EN defined, a wait counter SHALL clear on SETUP and increment on each ACCESS cycle with pready=0.
- Counter reaching TIMEOUT with pready=0: done[grant] pulses with err=1, rdata unchanged, psel=penable=0, go to IDLE with no back-to-back.
REQ-017 Without APB_ARB_TIMEOUT_EN, the block SHALL have no counter, SHALL wait indefinitely, and err SHALL be tied to 0.

Structure
REQ-018 Package apb_arb_pkg SHALL hold the state enum typedef (IDLE, SETUP, ACCESS) and the default WIDTH, NREQ and TIMEOUT constants.
REQ-019 Sub-module rr_arbiter SHALL be combinational: (eligible vector, last_grant) -> (grant index, any_valid).

Verification
REQ-020 Single read: req[2]=1, addr 0x0040, pready=1 immediately, prdata=0xBEEF -> psel high 2 cycles, penable 1 cycle, done[2] pulse, rdata=0xBEEF.
REQ-021 Wait states: write to 0x0010 with data 0x1234, pready low 3 ACCESS cycles -> paddr, pwdata and pwrite stable for all 5 psel cycles; done[0] on the 4th ACCESS cycle's completion; rdata unchanged.
REQ-022 Contention: req=4'b1111 held and re-raised after each done -> grant order 0,1,2,3,0; psel never drops between transfers; each SETUP follows a completion edge.
REQ-023 Fairness masking: only req[1] asserted and dropped in its done cycle -> exactly one transfer; psel returns to 0.
REQ-024 Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT=15): pready stuck at 0 -> done with err=1 after 15 wait cycles; next req is serviced normally.
REQ-025 Reset mid-ACCESS: preset_n pulled low -> psel and penable go to 0 immediately, no done pulse; after release, requester 0 has priority.
